// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the decode and execute stages: opcodes,
// control encodings and the ID/EX pipeline register layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ALU_PASS_B forwards the immediate (LUI); ALU_ADD_PC adds the immediate to pc.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10,
        ALU_ADD_PC = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        alu_op_e         alu_op;
        logic            alu_src;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
        wb_sel_e         wb_sel;
        logic            branch;
        logic            jump;
    } idex_t;

    // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it for both.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                               input logic       funct7_5,
                                               input logic       is_op);
        case (funct3)
            3'd0:    return (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return funct7_5 ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// 32-entry register file: two asynchronous read ports with write-through
// bypass, one synchronous write port, x0 hard-wired to zero.
module register_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs_q [32];
    logic             wr_active;

    assign wr_active = wr_en && (wr_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_active) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = (wr_active && wr_addr == rs1_addr) ? wr_data : regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            rs2_data = (wr_active && wr_addr == rs2_addr) ? wr_data : regs_q[rs2_addr];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: control decode, immediate generation, load-use hazard
// detection and the ID/EX pipeline register.
module instruction_decode
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_IFID,
    input  logic [WIDTH-1:0] pc_4_IFID,
    input  logic [WIDTH-1:0] instruction_IFID,
    input  logic             flush_EXID,
    input  logic             reg_wr_WBID,
    input  logic [4:0]       rd_WBID,
    input  logic [WIDTH-1:0] rd_data_WBID,
    output logic             stall_IDIF,
    output logic [WIDTH-1:0] pc_IDEX,
    output logic [WIDTH-1:0] pc_4_IDEX,
    output logic [WIDTH-1:0] rs1_data_IDEX,
    output logic [WIDTH-1:0] rs2_data_IDEX,
    output logic [WIDTH-1:0] imm_IDEX,
    output logic [4:0]       rs1_IDEX,
    output logic [4:0]       rs2_IDEX,
    output logic [4:0]       rd_IDEX,
    output logic [2:0]       funct3_IDEX,
    output logic [3:0]       alu_op_IDEX,
    output logic             alu_src_IDEX,
    output logic             mem_rd_IDEX,
    output logic             mem_wr_IDEX,
    output logic             reg_wr_IDEX,
    output logic [1:0]       wb_sel_IDEX,
    output logic             branch_IDEX,
    output logic             jump_IDEX
);

    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [4:0]       rs1, rs2, rd;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_data, rs2_data;
    logic [31:0]      imm;
    imm_type_e        imm_type;
    alu_op_e          alu_op;
    wb_sel_e          wb_sel;
    logic             valid, alu_src, mem_rd, mem_wr, reg_wr, branch, jump;
    logic             use_rs1, use_rs2, bubble;
    idex_t            idex_d, idex_q;

    assign instr  = instruction_IFID;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    register_file #(.WIDTH(WIDTH)) u_register_file (
        .clk      (clk),
        .reset    (reset),
        .rs1_addr (rs1),
        .rs2_addr (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (reg_wr_WBID),
        .wr_addr  (rd_WBID),
        .wr_data  (rd_data_WBID)
    );

    always_comb begin
        valid    = 1'b1;
        imm_type = IMM_NONE;
        alu_op   = ALU_ADD;
        alu_src  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        reg_wr   = 1'b0;
        wb_sel   = WB_ALU;
        branch   = 1'b0;
        jump     = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OPC_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASS_B; alu_src = 1'b1; reg_wr = 1'b1; end
            OPC_AUIPC:  begin imm_type = IMM_U; alu_op = ALU_ADD_PC; alu_src = 1'b1; reg_wr = 1'b1; end
            OPC_JAL: begin
                imm_type = IMM_J; alu_op = ALU_ADD_PC; alu_src = 1'b1;
                reg_wr = 1'b1; wb_sel = WB_PC4; jump = 1'b1;
            end
            OPC_JALR: begin
                imm_type = IMM_I; alu_src = 1'b1; reg_wr = 1'b1;
                wb_sel = WB_PC4; jump = 1'b1; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = IMM_B; alu_op = ALU_SUB; branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                imm_type = IMM_I; alu_src = 1'b1; mem_rd = 1'b1;
                reg_wr = 1'b1; wb_sel = WB_MEM; use_rs1 = 1'b1;
            end
            OPC_STORE:  begin imm_type = IMM_S; alu_src = 1'b1; mem_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OPC_OP_IMM: begin
                imm_type = IMM_I; alu_op = alu_from_funct(funct3, instr[30], 1'b0);
                alu_src = 1'b1; reg_wr = 1'b1; use_rs1 = 1'b1;
            end
            OPC_OP: begin
                alu_op = alu_from_funct(funct3, instr[30], 1'b1);
                reg_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default:    valid = 1'b0;
        endcase
    end

    always_comb begin
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // A load in EX whose destination this instruction reads cannot be forwarded yet.
    assign stall_IDIF = !reset && !flush_EXID && idex_q.mem_rd && (idex_q.rd != 5'd0)
                        && ((use_rs1 && rs1 == idex_q.rd) || (use_rs2 && rs2 == idex_q.rd));

    assign bubble = flush_EXID || stall_IDIF || !valid;

    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.pc       = pc_IFID;
            idex_d.pc_4     = pc_4_IFID;
            idex_d.rs1_data = rs1_data;
            idex_d.rs2_data = rs2_data;
            idex_d.imm      = imm;
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = rd;
            idex_d.funct3   = funct3;
            idex_d.alu_op   = alu_op;
            idex_d.alu_src  = alu_src;
            idex_d.mem_rd   = mem_rd;
            idex_d.mem_wr   = mem_wr;
            idex_d.reg_wr   = reg_wr;
            idex_d.wb_sel   = wb_sel;
            idex_d.branch   = branch;
            idex_d.jump     = jump;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign pc_IDEX       = idex_q.pc;
    assign pc_4_IDEX     = idex_q.pc_4;
    assign rs1_data_IDEX = idex_q.rs1_data;
    assign rs2_data_IDEX = idex_q.rs2_data;
    assign imm_IDEX      = idex_q.imm;
    assign rs1_IDEX      = idex_q.rs1;
    assign rs2_IDEX      = idex_q.rs2;
    assign rd_IDEX       = idex_q.rd;
    assign funct3_IDEX   = idex_q.funct3;
    assign alu_op_IDEX   = idex_q.alu_op;
    assign alu_src_IDEX  = idex_q.alu_src;
    assign mem_rd_IDEX   = idex_q.mem_rd;
    assign mem_wr_IDEX   = idex_q.mem_wr;
    assign reg_wr_IDEX   = idex_q.reg_wr;
    assign wb_sel_IDEX   = idex_q.wb_sel;
    assign branch_IDEX   = idex_q.branch;
    assign jump_IDEX     = idex_q.jump;

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed instructions push expected
// stall and ID/EX values; a negedge monitor pops and compares them.
module tb_instruction_decode;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_IFID = '0, pc_4_IFID = '0, instruction_IFID = '0;
    logic        flush_EXID = 1'b0, reg_wr_WBID = 1'b0;
    logic [4:0]  rd_WBID = '0;
    logic [31:0] rd_data_WBID = '0;
    logic        stall_IDIF;
    logic [31:0] pc_IDEX, pc_4_IDEX, rs1_data_IDEX, rs2_data_IDEX, imm_IDEX;
    logic [4:0]  rs1_IDEX, rs2_IDEX, rd_IDEX;
    logic [2:0]  funct3_IDEX;
    logic [3:0]  alu_op_IDEX;
    logic        alu_src_IDEX, mem_rd_IDEX, mem_wr_IDEX, reg_wr_IDEX;
    logic [1:0]  wb_sel_IDEX;
    logic        branch_IDEX, jump_IDEX;

    instruction_decode #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .pc_IFID(pc_IFID), .pc_4_IFID(pc_4_IFID), .instruction_IFID(instruction_IFID),
        .flush_EXID(flush_EXID),
        .reg_wr_WBID(reg_wr_WBID), .rd_WBID(rd_WBID), .rd_data_WBID(rd_data_WBID),
        .stall_IDIF(stall_IDIF),
        .pc_IDEX(pc_IDEX), .pc_4_IDEX(pc_4_IDEX),
        .rs1_data_IDEX(rs1_data_IDEX), .rs2_data_IDEX(rs2_data_IDEX), .imm_IDEX(imm_IDEX),
        .rs1_IDEX(rs1_IDEX), .rs2_IDEX(rs2_IDEX), .rd_IDEX(rd_IDEX), .funct3_IDEX(funct3_IDEX),
        .alu_op_IDEX(alu_op_IDEX), .alu_src_IDEX(alu_src_IDEX), .mem_rd_IDEX(mem_rd_IDEX),
        .mem_wr_IDEX(mem_wr_IDEX), .reg_wr_IDEX(reg_wr_IDEX), .wb_sel_IDEX(wb_sel_IDEX),
        .branch_IDEX(branch_IDEX), .jump_IDEX(jump_IDEX)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    due;
        int    id;
        logic  stall;
        idex_t out;
    } chk_t;

    chk_t  stall_q[$];
    chk_t  out_q[$];
    int    cyc = 0;
    int    step_id = 0;
    int    checks = 0;
    int    errors = 0;
    idex_t bub;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic idex_t mk(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                                 input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [2:0] f3, input alu_op_e alu,
                                 input logic src, input logic mrd, input logic mwr, input logic rwr,
                                 input wb_sel_e wb, input logic br, input logic jmp);
        idex_t e;
        e.pc = pc;         e.pc_4 = pc + 32'd4;
        e.rs1_data = rs1d; e.rs2_data = rs2d; e.imm = imm;
        e.rs1 = rs1;       e.rs2 = rs2;       e.rd = rd;   e.funct3 = f3;
        e.alu_op = alu;    e.alu_src = src;   e.mem_rd = mrd; e.mem_wr = mwr;
        e.reg_wr = rwr;    e.wb_sel = wb;     e.branch = br;  e.jump = jmp;
        return e;
    endfunction

    // Inputs applied just after a posedge; stall is due this cycle, ID/EX next cycle.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                        input logic wr, input logic [4:0] rd, input logic [31:0] data,
                        input logic rst, input logic exp_stall, input idex_t exp_out);
        chk_t c;
        @(posedge clk);
        #1;
        instruction_IFID = instr;
        pc_IFID          = pc;
        pc_4_IFID        = pc + 32'd4;
        flush_EXID       = flush;
        reg_wr_WBID      = wr;
        rd_WBID          = rd;
        rd_data_WBID     = data;
        reset            = rst;
        step_id++;
        c.id    = step_id;
        c.stall = exp_stall;
        c.out   = exp_out;
        c.due   = cyc;
        stall_q.push_back(c);
        c.due   = cyc + 1;
        out_q.push_back(c);
    endtask

    always @(negedge clk) begin
        chk_t  c;
        idex_t act;
        act.pc = pc_IDEX;           act.pc_4 = pc_4_IDEX;
        act.rs1_data = rs1_data_IDEX; act.rs2_data = rs2_data_IDEX; act.imm = imm_IDEX;
        act.rs1 = rs1_IDEX;         act.rs2 = rs2_IDEX;   act.rd = rd_IDEX;
        act.funct3 = funct3_IDEX;   act.alu_op = alu_op_e'(alu_op_IDEX);
        act.alu_src = alu_src_IDEX; act.mem_rd = mem_rd_IDEX; act.mem_wr = mem_wr_IDEX;
        act.reg_wr = reg_wr_IDEX;   act.wb_sel = wb_sel_e'(wb_sel_IDEX);
        act.branch = branch_IDEX;   act.jump = jump_IDEX;
        while (stall_q.size() > 0 && stall_q[0].due <= cyc) begin
            c = stall_q.pop_front();
            checks++;
            if (stall_IDIF !== c.stall) begin
                errors++;
                $display("FAIL stall step %0d: got %b, expected %b", c.id, stall_IDIF, c.stall);
            end else begin
                $display("ok   stall step %0d: %b", c.id, stall_IDIF);
            end
        end
        while (out_q.size() > 0 && out_q[0].due <= cyc) begin
            c = out_q.pop_front();
            checks++;
            if (act !== c.out) begin
                errors++;
                $display("FAIL idex step %0d: got %h, expected %h", c.id, act, c.out);
            end else begin
                $display("ok   idex step %0d: %h", c.id, act);
            end
        end
    end

    localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
    localparam logic [31:0] I_ADD8  = 32'h00738433; // add  x8,x7,x7
    localparam logic [31:0] I_LW3   = 32'h0000A183; // lw   x3,0(x1)
    localparam logic [31:0] I_ADD4  = 32'h00218233; // add  x4,x3,x2
    localparam logic [31:0] I_ADD11 = 32'h000005B3; // add  x11,x0,x0
    localparam logic [31:0] I_LUI   = 32'h12345337; // lui  x6,0x12345
    localparam logic [31:0] I_SW    = 32'h0020A423; // sw   x2,8(x1)
    localparam logic [31:0] I_BEQ   = 32'hFE208CE3; // beq  x1,x2,-8
    localparam logic [31:0] I_JAL   = 32'h010000EF; // jal  x1,+16
    localparam logic [31:0] I_SRAI  = 32'h4032D293; // srai x5,x5,3
    localparam logic [31:0] I_ADD10 = 32'h00948533; // add  x10,x9,x9

    initial begin
        bub = '0;
        step(32'h0, 32'h0,   0, 0, 0, 0, 1, 0, bub);
        step(32'h0, 32'h0,   0, 0, 0, 0, 1, 0, bub);
        step(I_ADDI, 32'h100, 0, 0, 0, 0, 0, 0,
             mk(32'h100, 0, 0, 32'hFFFFFFFF, 0, 31, 5, 0, ALU_ADD, 1, 0, 0, 1, WB_ALU, 0, 0));
        step(I_ADD8, 32'h104, 0, 1, 7, 32'h1234, 0, 0,
             mk(32'h104, 32'h1234, 32'h1234, 0, 7, 7, 8, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_ADD8, 32'h108, 0, 0, 0, 0, 0, 0,
             mk(32'h108, 32'h1234, 32'h1234, 0, 7, 7, 8, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_LW3, 32'h10C, 0, 1, 2, 32'h22, 0, 0,
             mk(32'h10C, 0, 0, 0, 1, 0, 3, 2, ALU_ADD, 1, 1, 0, 1, WB_MEM, 0, 0));
        step(I_ADD4, 32'h110, 0, 0, 0, 0, 0, 1, bub);
        step(I_ADD4, 32'h110, 0, 0, 0, 0, 0, 0,
             mk(32'h110, 0, 32'h22, 0, 3, 2, 4, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_LW3, 32'h114, 0, 0, 0, 0, 0, 0,
             mk(32'h114, 0, 0, 0, 1, 0, 3, 2, ALU_ADD, 1, 1, 0, 1, WB_MEM, 0, 0));
        step(I_ADD4, 32'h118, 1, 0, 0, 0, 0, 0, bub);
        step(I_ADD4, 32'h118, 0, 0, 0, 0, 0, 0,
             mk(32'h118, 0, 32'h22, 0, 3, 2, 4, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_ADD11, 32'h11C, 0, 1, 0, 32'hDEAD, 0, 0,
             mk(32'h11C, 0, 0, 0, 0, 0, 11, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_ADD11, 32'h120, 0, 0, 0, 0, 0, 0,
             mk(32'h120, 0, 0, 0, 0, 0, 11, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(32'h0, 32'h124, 0, 0, 0, 0, 0, 0, bub);
        step(I_LUI, 32'h128, 0, 0, 0, 0, 0, 0,
             mk(32'h128, 0, 0, 32'h12345000, 8, 3, 6, 5, ALU_PASS_B, 1, 0, 0, 1, WB_ALU, 0, 0));
        step(I_SW, 32'h12C, 0, 0, 0, 0, 0, 0,
             mk(32'h12C, 0, 32'h22, 32'h8, 1, 2, 8, 2, ALU_ADD, 1, 0, 1, 0, WB_ALU, 0, 0));
        step(I_BEQ, 32'h130, 0, 0, 0, 0, 0, 0,
             mk(32'h130, 0, 32'h22, 32'hFFFFFFF8, 1, 2, 25, 0, ALU_SUB, 0, 0, 0, 0, WB_ALU, 1, 0));
        step(I_JAL, 32'h134, 0, 0, 0, 0, 0, 0,
             mk(32'h134, 0, 0, 32'h10, 0, 16, 1, 0, ALU_ADD_PC, 1, 0, 0, 1, WB_PC4, 0, 1));
        step(I_SRAI, 32'h138, 0, 0, 0, 0, 0, 0,
             mk(32'h138, 0, 0, 32'h403, 5, 3, 5, 5, ALU_SRA, 1, 0, 0, 1, WB_ALU, 0, 0));
        step(I_ADD10, 32'h13C, 0, 1, 9, 32'h99, 0, 0,
             mk(32'h13C, 32'h99, 32'h99, 0, 9, 9, 10, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_LW3, 32'h140, 0, 0, 0, 0, 0, 0,
             mk(32'h140, 0, 0, 0, 1, 0, 3, 2, ALU_ADD, 1, 1, 0, 1, WB_MEM, 0, 0));
        step(I_ADD4, 32'h144, 0, 1, 9, 32'h77, 1, 0, bub);
        step(I_ADD10, 32'h144, 0, 0, 0, 0, 0, 0,
             mk(32'h144, 0, 0, 0, 9, 9, 10, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(I_ADD4, 32'h148, 0, 0, 0, 0, 0, 0,
             mk(32'h148, 0, 0, 0, 3, 2, 4, 0, ALU_ADD, 0, 0, 0, 1, WB_ALU, 0, 0));
        step(32'h0, 32'h14C, 0, 0, 0, 0, 0, 0, bub);

        for (int i = 0; i < 20 && (out_q.size() > 0 || stall_q.size() > 0); i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (out_q.size() > 0 || stall_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d idex and %0d stall checks still pending, expected 0",
                     out_q.size(), stall_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
